roundrobin_fixed_timeslice: RTL and testbench
=============================================

Name: roundrobin_fixed_timeslice

Overview:
- Registered round-robin arbiter for N requesters with a fixed per-grant time slice.
- Each grant is held for at most TIME_SLICE cycles while the holder keeps requesting. Priority then rotates to the requester after the last winner.
- Sits between request sources and a shared resource; GNT is one-hot or zero.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- TIME_SLICE, 1, maximum consecutive cycles a single grant is held (≥1).
- CNT_W, $clog2(TIME_SLICE+1), width of the slice counter (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-high: asserted when 1, despite the _n suffix.
- REQ  input  N_REQ  request vector; bit i = requester i wants the resource; sampled at rising clk.
- GNT  output  N_REQ  registered grant; one-hot or all-zero.

Behaviour:
- State: GNT register, last-winner pointer ptr (log2 N_REQ bits), slice counter cnt.
- Reset (rst_n=1, immediate, no clock needed): GNT=0, ptr=N_REQ-1 so requester 0 has top priority first, cnt=0. Reset mid-grant drops GNT to 0 at once.
- Each rising edge with rst_n=0, the block evaluates the rules below in order.
- Hold rule: if GNT≠0, REQ[ptr]=1 and cnt < TIME_SLICE-1, then GNT is unchanged and cnt increments.
- Otherwise, arbitrate:
  - Search REQ starting at index (ptr+1) mod N_REQ, ascending, wrapping.
  - The first set bit w wins: GNT=one-hot(w), ptr=w, cnt=0.
  - With TIME_SLICE=1 this re-arbitrates every cycle.
- The current holder is lowest priority in re-arbitration. If it is the only requester, it wins again and a new slice starts with cnt=0.
- Early release: if the holder deasserts REQ, the block re-arbitrates on that edge. Slice remainder is forfeited.
- No requests: GNT=0, ptr unchanged, cnt=0.
- Latency: REQ sampled at edge k gives GNT valid after edge k (one register stage). There is no combinational REQ→GNT path.
- Invariants:
  - At most one GNT bit set.
  - A GNT bit is set only if the corresponding REQ bit was set at the sampling edge.
  - Every continuously requesting input is granted within (N_REQ-1)*TIME_SLICE+1 arbitration cycles.
- Wrap-around: ptr=N_REQ-1 wraps the search to index 0.
- Simultaneous events: reset dominates all other activity. REQ changes between edges are ignored.

Test Plan:
- Reset then idle: rst_n pulsed 1 for 5 ns, REQ=0000 -> GNT=0000 held; asserting rst_n mid-grant forces GNT=0000 immediately, without a clock edge.
- Rotation sequence, TIME_SLICE=1: REQ changed each cycle to 0010,1110,0010,1010,0100,1111,0110,1000,0010,1010,0100 -> GNT one edge later: 0010,0100,0010,1000,0100,1000,0010,1000,0010,1000,0100.
- Fairness, all requesting, TIME_SLICE=1: REQ=1111 held 8 cycles after reset -> GNT 0001,0010,0100,1000,0001,0010,0100,1000.
- Time slice, TIME_SLICE=3: REQ=1111 held -> GNT=0001 for 3 cycles, then 0010 for 3, 0100 for 3, 1000 for 3, then 0001 again.
- Early release and sole requester, TIME_SLICE=3:
  - REQ=0011; requester 0 drops after 1 cycle of grant -> GNT switches to 0010 on the next edge.
  - REQ=0100 alone for 7 cycles -> GNT=0100 continuously (slice restarts).
- Wrap-around: after GNT=1000, REQ=1001 -> GNT=0001; then REQ=1000 -> GNT=1000.

Source files
------------

// File: rtl/roundrobin_fixed_timeslice.sv
// Registered round-robin arbiter with a fixed per-grant time slice.
// The holder keeps the grant for up to TIME_SLICE cycles, then priority rotates.
module roundrobin_fixed_timeslice #(
  parameter int N_REQ      = 4,
  parameter int TIME_SLICE = 1,
  parameter int CNT_W      = $clog2(TIME_SLICE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME_SLICE - 1);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic             hold;

  // Search starts just after the last winner, so the holder is checked last.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hold = (gnt_q != '0) && REQ[ptr_q] && (cnt_q < CNT_LAST);

  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (found) begin
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      ptr_d      = win;
      cnt_d      = '0;
    end else begin
      gnt_d = '0;
      cnt_d = '0;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      gnt_q <= '0;
      ptr_q <= PTR_RST;
      cnt_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign GNT = gnt_q;

endmodule

// File: tb/tb_roundrobin_fixed_timeslice.sv
// Bench for roundrobin_fixed_timeslice: one instance with a 1-cycle slice,
// one with a 3-cycle slice; expected grants queued as requests are driven.
module tb_roundrobin_fixed_timeslice;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req1, req3;
  logic [3:0] gnt1, gnt3;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  roundrobin_fixed_timeslice #(
    .N_REQ(4),
    .TIME_SLICE(1)
  ) dut1 (
    .clk(clk),
    .rst_n(rst),
    .REQ(req1),
    .GNT(gnt1)
  );

  roundrobin_fixed_timeslice #(
    .N_REQ(4),
    .TIME_SLICE(3)
  ) dut3 (
    .clk(clk),
    .rst_n(rst),
    .REQ(req3),
    .GNT(gnt3)
  );

  task automatic drive(input logic [3:0] r, input logic [3:0] e,
                       input bit ts3);
    if (ts3) req3 = r;
    else req1 = r;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req1 = '0;
    req3 = '0;
    #5;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] e;
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req1 = '0;
    req3 = '0;
    #1;
    checks++;
    if (gnt1 !== 4'b0000 || gnt3 !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: GNT1=%b GNT3=%b expected 0000", gnt1, gnt3);
    end
    #4;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt1 !== e) begin
        errors++;
        $display("FAIL idle %0d: GNT=%b expected %b", i, gnt1, e);
      end
    end
    drive(4'b0100, 4'b0100, 1'b0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (gnt1 !== e) begin
      errors++;
      $display("FAIL grant_before_reset: GNT=%b expected %b", gnt1, e);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt1 !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_mid_grant: GNT=%b expected 0000", gnt1);
    end
    #2;
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] rq [11];
    logic [3:0] gx [11];
    logic [3:0] e;
    rq = '{4'b0010, 4'b1110, 4'b0010, 4'b1010, 4'b0100, 4'b1111,
           4'b0110, 4'b1000, 4'b0010, 4'b1010, 4'b0100};
    gx = '{4'b0010, 4'b0100, 4'b0010, 4'b1000, 4'b0100, 4'b1000,
           4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0100};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(rq[i], gx[i], 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt1 !== e) begin
        errors++;
        $display("FAIL rotation %0d: GNT=%b expected %b", i, gnt1, e);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 4'b0001 << (i % 4), 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt1 !== e || !$onehot0(gnt1)) begin
        errors++;
        $display("FAIL fairness %0d: GNT=%b expected %b", i, gnt1, e);
      end
    end
  endtask

  task automatic test_time_slice();
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(4'b1111, 4'b0001 << ((i / 3) % 4), 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt3 !== e) begin
        errors++;
        $display("FAIL time_slice %0d: GNT=%b expected %b", i, gnt3, e);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] e;
    do_reset();
    drive(4'b0011, 4'b0001, 1'b1);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (gnt3 !== e) begin
      errors++;
      $display("FAIL early_first: GNT=%b expected %b", gnt3, e);
    end
    drive(4'b0010, 4'b0010, 1'b1);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (gnt3 !== e) begin
      errors++;
      $display("FAIL early_release: GNT=%b expected %b", gnt3, e);
    end
    for (int i = 0; i < 7; i++) begin
      drive(4'b0100, 4'b0100, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt3 !== e) begin
        errors++;
        $display("FAIL sole_requester %0d: GNT=%b expected %b", i, gnt3, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [3];
    logic [3:0] gx [3];
    logic [3:0] e;
    rq = '{4'b1000, 4'b1001, 4'b1000};
    gx = '{4'b1000, 4'b0001, 4'b1000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(rq[i], gx[i], 1'b0);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt1 !== e) begin
        errors++;
        $display("FAIL wrap %0d: GNT=%b expected %b", i, gnt1, e);
      end
    end
  endtask

  initial begin
    req1 = '0;
    req3 = '0;
    test_reset();
    test_rotation();
    test_fairness();
    test_time_slice();
    test_early_release();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
